// File: rtl/atm_account_arbiter.sv
// atm_account_arbiter: round-robin transaction scheduler over a shared account-balance array.
// Optional cumulative per-account withdraw limit enabled by defining ATM_WD_LIMIT_EN.
module atm_account_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int NUM_ACC     = 8,
  parameter int ACC_IDX_W   = 3,
  parameter int BAL_W       = 11,
  parameter int DEFAULT_BAL = 500,
  parameter int WD_LIMIT    = 1000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [2*NUM_REQ-1:0]           req_op,
  input  logic [ACC_IDX_W*NUM_REQ-1:0]   req_acc,
  input  logic [ACC_IDX_W*NUM_REQ-1:0]   req_dst,
  input  logic [BAL_W*NUM_REQ-1:0]       req_amount,
  output logic                           rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
  output logic                           rsp_error,
  output logic [BAL_W-1:0]               rsp_balance,
  output logic                           busy,
  input  logic                           wd_clear
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int AW   = $clog2(NUM_ACC);
  typedef enum logic [1:0] {IDLE, CALC, COMMIT, RESP} state_t;
  state_t state;
  logic [BAL_W-1:0] bal [NUM_ACC];
  logic [ID_W-1:0] rr, gid, id_r;
  logic [NUM_REQ-1:0] grant;
  logic [1:0] op_r;
  logic [ACC_IDX_W-1:0] acc_r, dst_r;
  logic [BAL_W-1:0] amt_r, src_bal, dst_bal, src_new, rsp_bal_r, dst_new_r;
  logic [BAL_W:0] src_sum, dst_sum;
  logic acc_ok, dst_ok, lim_err, err_c, err_r;
  // Descending scan so the nearest index after the last grant is assigned last and wins
  always_comb begin
    grant = '0;
    gid = rr;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_valid[(int'(rr) + k) % NUM_REQ]) gid = ID_W'((int'(rr) + k) % NUM_REQ);
    grant[gid] = |req_valid;
  end
  assign req_ready = (state == IDLE) ? grant : '0;
  assign busy = state != IDLE;
  assign acc_ok = 32'(acc_r) < NUM_ACC;
  assign dst_ok = 32'(dst_r) < NUM_ACC;
  assign src_bal = acc_ok ? bal[acc_r[AW-1:0]] : '0;
  assign dst_bal = dst_ok ? bal[dst_r[AW-1:0]] : '0;
  assign src_sum = {1'b0, src_bal} + {1'b0, amt_r};
  assign dst_sum = {1'b0, dst_bal} + {1'b0, amt_r};
`ifdef ATM_WD_LIMIT_EN
  logic [BAL_W:0] wd_cnt [NUM_ACC];
  logic [BAL_W+1:0] wd_sum;
  assign wd_sum = acc_ok ? {1'b0, wd_cnt[acc_r[AW-1:0]]} + (BAL_W+2)'(amt_r) : '0;
  assign lim_err = op_r[0] && (wd_sum > (BAL_W+2)'(WD_LIMIT));
  // A clear on the commit edge takes precedence over the counter update
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < NUM_ACC; i++) wd_cnt[i] <= '0;
    else if (wd_clear)
      for (int i = 0; i < NUM_ACC; i++) wd_cnt[i] <= '0;
    else if (state == COMMIT && !err_r && op_r[0])
      wd_cnt[acc_r[AW-1:0]] <= wd_sum[BAL_W:0];
`else
  logic wd_clear_unused;
  assign wd_clear_unused = wd_clear;
  assign lim_err = 1'b0;
`endif
  // Sum overflow into bit BAL_W means the result exceeds the maximum legal balance
  assign err_c = !acc_ok || lim_err ||
                 (op_r == 2'b01 && amt_r > src_bal) ||
                 (op_r == 2'b10 && src_sum[BAL_W]) ||
                 (op_r == 2'b11 && (!dst_ok || acc_r == dst_r || amt_r > src_bal || dst_sum[BAL_W]));
  assign src_new = op_r[0] ? src_bal - amt_r : op_r[1] ? src_sum[BAL_W-1:0] : src_bal;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rr <= '0;
      id_r <= '0;
      op_r <= '0;
      acc_r <= '0;
      dst_r <= '0;
      amt_r <= '0;
      err_r <= 1'b0;
      rsp_bal_r <= '0;
      dst_new_r <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_error <= 1'b0;
      rsp_balance <= '0;
      for (int i = 0; i < NUM_ACC; i++) bal[i] <= BAL_W'(DEFAULT_BAL);
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          id_r <= gid;
          op_r <= req_op[2*gid +: 2];
          acc_r <= req_acc[ACC_IDX_W*gid +: ACC_IDX_W];
          dst_r <= req_dst[ACC_IDX_W*gid +: ACC_IDX_W];
          amt_r <= req_amount[BAL_W*gid +: BAL_W];
          state <= CALC;
        end
        CALC: begin
          err_r <= err_c;
          rsp_bal_r <= err_c ? src_bal : src_new;
          dst_new_r <= dst_sum[BAL_W-1:0];
          state <= COMMIT;
        end
        COMMIT: begin
          if (!err_r) begin
            bal[acc_r[AW-1:0]] <= rsp_bal_r;
            if (op_r == 2'b11) bal[dst_r[AW-1:0]] <= dst_new_r;
          end
          rsp_valid <= 1'b1;
          rsp_id <= id_r;
          rsp_error <= err_r;
          rsp_balance <= rsp_bal_r;
          state <= RESP;
        end
        RESP: begin
          rr <= id_r;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_atm_account_arbiter.sv
// tb_atm_account_arbiter: directed ATM transactions against a per-cycle reference model
`timescale 1ns/1ps
module tb_atm_account_arbiter;
  localparam int NR = 2, NACC = 8, AW = 4, BW = 11, MAXB = 2047, WDL = 1000;
  logic clk = 1'b0, rst_n = 1'b0, wd_clear = 1'b0;
  logic [NR-1:0] req_valid = '0, req_ready;
  logic [2*NR-1:0] req_op = '0;
  logic [AW*NR-1:0] req_acc = '0, req_dst = '0;
  logic [BW*NR-1:0] req_amount = '0;
  logic rsp_valid, rsp_error, busy;
  logic [0:0] rsp_id;
  logic [BW-1:0] rsp_balance;
  int tests = 0, fails = 0;
  int mbal [NACC];
  int mcnt [NACC];
  int mrr, cyc = 0, free_at = 0, due = -1, p_id, p_err, p_bal, h_id, h_err, h_bal;
  int seq [4];
  int r_id, r_err, r_bal;

  always #5 clk = ~clk;

  atm_account_arbiter #(.NUM_REQ(NR), .NUM_ACC(NACC), .ACC_IDX_W(AW), .BAL_W(BW),
                        .DEFAULT_BAL(500), .WD_LIMIT(WDL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_acc(req_acc), .req_dst(req_dst), .req_amount(req_amount),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_error(rsp_error),
    .rsp_balance(rsp_balance), .busy(busy), .wd_clear(wd_clear));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_exec(input int op, input int a, input int d, input int amt,
                            output int e, output int rb);
    int lim;
    e = 0;
    rb = 0;
    lim = 0;
    if (a >= NACC) begin
      e = 1;
      return;
    end
`ifdef ATM_WD_LIMIT_EN
    lim = int'((op == 1 || op == 3) && mcnt[a] + amt > WDL);
`endif
    if (op == 1) e = int'(amt > mbal[a] || lim != 0);
    if (op == 2) e = int'(mbal[a] + amt > MAXB);
    if (op == 3) e = int'(d >= NACC || d == a || amt > mbal[a] || lim != 0 || mbal[d] + amt > MAXB);
    if (e == 0) begin
      if (op == 1 || op == 3) begin
        mbal[a] -= amt;
        mcnt[a] += amt;
      end
      if (op == 2) mbal[a] += amt;
      if (op == 3) mbal[d] += amt;
    end
    rb = mbal[a];
  endtask

  // Reference model: one check pass per cycle on the falling edge
  always @(negedge clk) begin
    int w;
    logic [NR-1:0] er;
    cyc++;
    if (!rst_n) begin
      foreach (mbal[i]) begin
        mbal[i] = 500;
        mcnt[i] = 0;
      end
      mrr = 0;
      free_at = 0;
      due = -1;
      h_id = 0;
      h_err = 0;
      h_bal = 0;
    end else begin
      er = '0;
      if (wd_clear) foreach (mcnt[i]) mcnt[i] = 0;
      chk("busy", int'(busy), int'(cyc < free_at));
      if (cyc >= free_at && req_valid != '0) begin
        w = -1;
        for (int k = 1; k <= NR; k++)
          if (w < 0 && req_valid[(mrr + k) % NR]) w = (mrr + k) % NR;
        er[w] = 1'b1;
        mrr = w;
        free_at = cyc + 4;
        due = cyc + 3;
        p_id = w;
        model_exec(int'(req_op[2*w +: 2]), int'(req_acc[AW*w +: AW]), int'(req_dst[AW*w +: AW]),
                   int'(req_amount[BW*w +: BW]), p_err, p_bal);
      end
      chk("req_ready", int'(req_ready), int'(er));
      if (cyc == due) begin
        h_id = p_id;
        h_err = p_err;
        h_bal = p_bal;
      end
      chk("rsp_valid", int'(rsp_valid), int'(cyc == due));
      chk("rsp_id", int'(rsp_id), h_id);
      chk("rsp_error", int'(rsp_error), h_err);
      chk("rsp_balance", int'(rsp_balance), h_bal);
    end
  end

  task automatic txn(input int id, input int op, input int a, input int d, input int amt,
                     output int oid, output int oerr, output int obal);
    int n;
    @(posedge clk);
    #1;
    req_op[2*id +: 2] = 2'(op);
    req_acc[AW*id +: AW] = AW'(a);
    req_dst[AW*id +: AW] = AW'(d);
    req_amount[BW*id +: BW] = BW'(amt);
    req_valid[id] = 1'b1;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ready[id]) break;
    end
    if (n == 40) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    if (n == 40) chk("rsp_timeout", 0, 1);
    oid = int'(rsp_id);
    oerr = int'(rsp_error);
    obal = int'(rsp_balance);
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, int'(rsp_id), 0);
    chk({tag, "_rsp_error"}, int'(rsp_error), 0);
    chk({tag, "_rsp_balance"}, int'(rsp_balance), 0);
    chk({tag, "_req_ready"}, int'(req_ready), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    reset_outputs_zero("reset");
    rst_n = 1'b1;
    txn(0, 0, 1, 0, 0, r_id, r_err, r_bal);
    chk("bal1_id", r_id, 0);
    chk("bal1_err", r_err, 0);
    chk("bal1_bal", r_bal, 500);
    txn(0, 1, 1, 0, 100, r_id, r_err, r_bal);
    chk("wd100_err", r_err, 0);
    chk("wd100_bal", r_bal, 400);
    txn(0, 1, 1, 0, 2047, r_id, r_err, r_bal);
    chk("wd_big_err", r_err, 1);
    chk("wd_big_bal", r_bal, 400);
    txn(0, 0, 1, 0, 0, r_id, r_err, r_bal);
    chk("bal1_after", r_bal, 400);
    txn(0, 3, 1, 5, 50, r_id, r_err, r_bal);
    chk("xfer_err", r_err, 0);
    chk("xfer_bal", r_bal, 350);
    txn(0, 0, 5, 0, 0, r_id, r_err, r_bal);
    chk("bal5", r_bal, 550);
    txn(0, 3, 1, 5, 1600, r_id, r_err, r_bal);
    chk("xfer_ovf_err", r_err, 1);
    chk("xfer_ovf_bal", r_bal, 350);
    txn(0, 0, 5, 0, 0, r_id, r_err, r_bal);
    chk("bal5_kept", r_bal, 550);
    txn(0, 3, 2, 2, 10, r_id, r_err, r_bal);
    chk("xfer_self_err", r_err, 1);
    chk("xfer_self_bal", r_bal, 500);
    txn(0, 3, 2, 9, 10, r_id, r_err, r_bal);
    chk("xfer_baddst_err", r_err, 1);
    txn(0, 1, 2, 0, 0, r_id, r_err, r_bal);
    chk("wd0_err", r_err, 0);
    chk("wd0_bal", r_bal, 500);
    // Both requesters held: last grant was 0, so rotation starts at 1
    @(posedge clk);
    #1;
    req_op = 4'b0000;
    req_acc = {4'd6, 4'd5};
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      for (n = 0; n < 40; n++) begin
        @(negedge clk);
        if (rsp_valid) break;
      end
      if (n == 40) chk("rr_timeout", 0, 1);
      seq[g] = int'(rsp_id);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("rr_g0", seq[0], 1);
    chk("rr_g1", seq[1], 0);
    chk("rr_g2", seq[2], 1);
    chk("rr_g3", seq[3], 0);
    txn(1, 0, 9, 0, 0, r_id, r_err, r_bal);
    chk("badidx_id", r_id, 1);
    chk("badidx_err", r_err, 1);
    chk("badidx_bal", r_bal, 0);
    txn(0, 2, 3, 0, 1547, r_id, r_err, r_bal);
    chk("dep_max_err", r_err, 0);
    chk("dep_max_bal", r_bal, 2047);
    txn(0, 2, 3, 0, 1, r_id, r_err, r_bal);
    chk("dep_ovf_err", r_err, 1);
    chk("dep_ovf_bal", r_bal, 2047);
    // Reset pulse while a withdraw sits in CALC
    @(posedge clk);
    #1;
    req_op[1:0] = 2'b01;
    req_acc[3:0] = 4'd0;
    req_amount[BW-1:0] = BW'(100);
    req_valid[0] = 1'b1;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ready[0]) break;
    end
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    reset_outputs_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    txn(0, 0, 0, 0, 0, r_id, r_err, r_bal);
    chk("rst_bal0", r_bal, 500);
    txn(0, 0, 1, 0, 0, r_id, r_err, r_bal);
    chk("rst_bal1", r_bal, 500);
    txn(0, 0, 3, 0, 0, r_id, r_err, r_bal);
    chk("rst_bal3", r_bal, 500);
    txn(0, 2, 0, 0, 1000, r_id, r_err, r_bal);
    chk("lim_dep", r_bal, 1500);
    txn(0, 1, 0, 0, 400, r_id, r_err, r_bal);
    chk("lim_wd1", r_bal, 1100);
    txn(0, 1, 0, 0, 400, r_id, r_err, r_bal);
    chk("lim_wd2", r_bal, 700);
    txn(0, 1, 0, 0, 300, r_id, r_err, r_bal);
`ifdef ATM_WD_LIMIT_EN
    chk("lim_wd3_err", r_err, 1);
    chk("lim_wd3_bal", r_bal, 700);
`else
    chk("lim_wd3_err", r_err, 0);
    chk("lim_wd3_bal", r_bal, 400);
`endif
    @(posedge clk);
    #1;
    wd_clear = 1'b1;
    @(posedge clk);
    #1;
    wd_clear = 1'b0;
    txn(0, 1, 0, 0, 300, r_id, r_err, r_bal);
    chk("lim_wd4_err", r_err, 0);
`ifdef ATM_WD_LIMIT_EN
    chk("lim_wd4_bal", r_bal, 400);
`else
    chk("lim_wd4_bal", r_bal, 100);
`endif
    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
